// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset driver with lock qualification, staggered downstream reset release,
// lock-loss re-arm, timeout retry and lock statistics. Single clock domain (refclk).
module pll_lock_reset_sequencer #(
   parameter int NUM_CHANNELS        = 4,
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 32,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int CNT_W               = 8
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    locked_in,
   input  logic                    force_relock,
   input  logic                    clear_stats,
   output logic                    pll_rst,
   output logic [NUM_CHANNELS-1:0] chan_rst,
   output logic                    all_ready,
   output logic [CNT_W-1:0]        lock_loss_count,
   output logic                    timeout_err
);

   localparam int REL_SPAN = STAGGER_CYCLES * (NUM_CHANNELS - 1);
   localparam int STB_LIM  = (LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0;
   localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_MAX  = (MAX_A > REL_SPAN + 1) ? MAX_A : REL_SPAN + 1;
   localparam int CW       = $clog2(CNT_MAX + 1);
   localparam int TW       = $clog2(LOCK_TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST  = CW'(STB_LIM);
   localparam logic [CW-1:0] REL_LAST  = CW'(REL_SPAN);
   localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      PLL_RESET,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    pll_rst_q, pll_rst_d;
   logic [NUM_CHANNELS-1:0] chan_q, chan_d;
   logic                    rdy_q, rdy_d;
   logic [CNT_W-1:0]        loss_q, loss_d;
   logic                    terr_q, terr_d;
   logic                    lock_s;
   logic                    lost, tout, rearm;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      pll_rst_d = pll_rst_q;
      chan_d    = chan_q;
      rdy_d     = rdy_q;
      loss_d    = loss_q;
      terr_d    = terr_q;
      lost      = 1'b0;
      tout      = 1'b0;
      rearm     = force_relock && (state_q != PLL_RESET);

      case (state_q)
         PLL_RESET: begin
            if (force_relock) begin
               cnt_d = '0;
            end else if (cnt_q == PRST_LAST) begin
               state_d   = WAIT_LOCK;
               pll_rst_d = 1'b0;
               tmo_d     = '0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
               tout = 1'b1;
            end else if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         end
         STABLE: begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
               tout = 1'b1;
            end else if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STB_LAST) begin
               // The stability window includes the cycle WAIT_LOCK first saw lock.
               cnt_d = '0;
               for (int i = 0; i < NUM_CHANNELS; i++) chan_d[i] = (i != 0);
               rdy_d   = (REL_SPAN == 0);
               state_d = (REL_SPAN == 0) ? RUN : RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               lost = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               for (int i = 1; i < NUM_CHANNELS; i++) begin
                  if (int'(cnt_q) + 1 >= STAGGER_CYCLES * i) chan_d[i] = 1'b0;
               end
               if (cnt_q + 1'b1 == REL_LAST) begin
                  rdy_d   = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (!lock_s) lost = 1'b1;
         end
         default: state_d = PLL_RESET;
      endcase

      if (lost || tout || rearm) begin
         state_d   = PLL_RESET;
         cnt_d     = '0;
         tmo_d     = '0;
         pll_rst_d = 1'b1;
         chan_d    = '1;
         rdy_d     = 1'b0;
      end
      if (lost && (loss_q != '1)) loss_d = loss_q + 1'b1;
      if (tout) terr_d = 1'b1;
      if (clear_stats) begin
         loss_d = '0;
         terr_d = 1'b0;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= PLL_RESET;
         sync_q    <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         pll_rst_q <= 1'b1;
         chan_q    <= '1;
         rdy_q     <= 1'b0;
         loss_q    <= '0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], locked_in};
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         pll_rst_q <= pll_rst_d;
         chan_q    <= chan_d;
         rdy_q     <= rdy_d;
         loss_q    <= loss_d;
         terr_q    <= terr_d;
      end
   end

   assign pll_rst         = pll_rst_q;
   assign chan_rst        = chan_q;
   assign all_ready       = rdy_q;
   assign lock_loss_count = loss_q;
   assign timeout_err     = terr_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench for pll_lock_reset_sequencer: event-level reference model checked every
// cycle, plus directed scenarios with hand-derived cycle-exact expectations.
module tb_pll_lock_reset_sequencer;

   localparam int NCH      = 3;
   localparam int SYNC     = 2;
   localparam int PRC      = 4;
   localparam int STB      = 8;
   localparam int STAG     = 2;
   localparam int TMO      = 40;
   localparam int CW       = 2;
   localparam int LOSS_MAX = (1 << CW) - 1;

   logic           refclk = 1'b0;
   logic           rst = 1'b1;
   logic           locked_in = 1'b0;
   logic           force_relock = 1'b0;
   logic           clear_stats = 1'b0;
   logic           pll_rst;
   logic [NCH-1:0] chan_rst;
   logic           all_ready;
   logic [CW-1:0]  lock_loss_count;
   logic           timeout_err;

   pll_lock_reset_sequencer #(
      .NUM_CHANNELS(NCH), .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC),
      .LOCK_STABLE_CYCLES(STB), .STAGGER_CYCLES(STAG),
      .LOCK_TIMEOUT_CYCLES(TMO), .CNT_W(CW)
   ) dut (
      .refclk(refclk), .rst(rst), .locked_in(locked_in),
      .force_relock(force_relock), .clear_stats(clear_stats),
      .pll_rst(pll_rst), .chan_rst(chan_rst), .all_ready(all_ready),
      .lock_loss_count(lock_loss_count), .timeout_err(timeout_err)
   );

   always #5 refclk = ~refclk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: attempt phase tracked by lock-run length and release age, not FSM states.
   typedef struct packed {
      logic [SYNC-1:0] sh;
      logic            prst;
      int              prst_done;
      int              tmo;
      int              run;
      logic            rel;
      int              rel_age;
      int              loss;
      logic            terr;
   } mdl_t;

   mdl_t m;
   bit   m_ok = 1'b0;

   function automatic mdl_t mdl_next(input mdl_t c, input logic r, input logic lk,
                                     input logic frc, input logic clr);
      mdl_t n;
      logic ls, lost, tout, restart;
      n = c;
      lost = 1'b0; tout = 1'b0; restart = 1'b0;
      if (r) begin
         n = '0;
         n.prst = 1'b1;
         return n;
      end
      ls   = c.sh[SYNC-1];
      n.sh = {c.sh[SYNC-2:0], lk};
      if (c.prst) begin
         if (frc) n.prst_done = 0;
         else begin
            n.prst_done = c.prst_done + 1;
            if (n.prst_done == PRC) begin
               n.prst = 1'b0; n.prst_done = 0; n.tmo = 0; n.run = 0;
            end
         end
      end else if (c.rel) begin
         lost    = !ls;
         restart = lost || frc;
         if (c.rel_age < 1000) n.rel_age = c.rel_age + 1;
      end else begin
         n.tmo   = c.tmo + 1;
         tout    = (n.tmo == TMO);
         restart = tout || frc;
         n.run   = ls ? c.run + 1 : 0;
         if (n.run == STB) begin
            n.rel = 1'b1; n.rel_age = 0;
         end
      end
      if (restart) begin
         n.prst = 1'b1; n.prst_done = 0; n.tmo = 0; n.run = 0; n.rel = 1'b0; n.rel_age = 0;
      end
      if (lost && c.loss < LOSS_MAX) n.loss = c.loss + 1;
      if (tout) n.terr = 1'b1;
      if (clr) begin
         n.loss = 0; n.terr = 1'b0;
      end
      return n;
   endfunction

   function automatic logic [NCH-1:0] exp_chan(input mdl_t c);
      logic [NCH-1:0] e;
      for (int i = 0; i < NCH; i++) e[i] = !(c.rel && c.rel_age >= STAG * i);
      return e;
   endfunction

   always @(posedge refclk) begin
      m <= mdl_next(m, rst, locked_in, force_relock, clear_stats);
      if (rst) m_ok <= 1'b1;
   end

   always @(negedge refclk) begin
      if (m_ok) begin
         chk("model pll_rst", int'(pll_rst), int'(m.prst));
         chk("model chan_rst", int'(chan_rst), int'(exp_chan(m)));
         chk("model all_ready", int'(all_ready), int'(m.rel && m.rel_age >= STAG * (NCH - 1)));
         chk("model lock_loss_count", int'(lock_loss_count), m.loss);
         chk("model timeout_err", int'(timeout_err), int'(m.terr));
      end
   end

   task automatic tick();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!all_ready && n < 80) begin
         tick();
         n++;
      end
      chk(name, int'(all_ready), 1);
   endtask

   task automatic drop_lock_3();
      locked_in = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      int prh, bad, base, n;

      // Power-up
      do_reset();
      chk("s1 reset chan_rst", int'(chan_rst), 3'b111);
      chk("s1 reset lock_loss_count", int'(lock_loss_count), 0);
      prh = 0;
      for (int k = 0; k <= 21; k++) begin
         if (k == 6) locked_in = 1'b1;
         if (pll_rst) prh++;
         if (k == 15) chk("s1 chan@15", int'(chan_rst), 3'b111);
         if (k == 16) chk("s1 chan@16", int'(chan_rst), 3'b110);
         if (k == 17) chk("s1 chan@17", int'(chan_rst), 3'b110);
         if (k == 18) chk("s1 chan@18", int'(chan_rst), 3'b100);
         if (k == 19) chk("s1 all_ready@19", int'(all_ready), 0);
         if (k == 20) chk("s1 chan@20", int'(chan_rst), 3'b000);
         if (k == 20) chk("s1 all_ready@20", int'(all_ready), 1);
         tick();
      end
      chk("s1 pll_rst high cycles", prh, 4);

      // Lock glitch during STABLE
      locked_in = 1'b1;
      do_reset();
      bad = 0;
      for (int k = 0; k <= 20; k++) begin
         if (k == 7) locked_in = 1'b0;
         if (k == 10) locked_in = 1'b1;
         if (k < 20 && chan_rst != 3'b111) bad++;
         if (k == 20) chk("s2 chan@20", int'(chan_rst), 3'b110);
         if (k == 20) chk("s2 lock_loss_count", int'(lock_loss_count), 0);
         if (k < 20) tick();
      end
      chk("s2 early release count", bad, 0);

      // Loss in RUN
      go_to(24);
      chk("s3 running all_ready", int'(all_ready), 1);
      go_to(30);
      locked_in = 1'b0;
      go_to(32);
      chk("s3 chan@fall+2", int'(chan_rst), 3'b000);
      tick();
      chk("s3 chan@fall+3", int'(chan_rst), 3'b111);
      chk("s3 all_ready@fall+3", int'(all_ready), 0);
      chk("s3 count after loss", int'(lock_loss_count), 1);
      locked_in = 1'b1;
      prh = 0;
      for (int k = 0; k < 5; k++) begin
         if (pll_rst) prh++;
         tick();
      end
      chk("s3 pll_rst pulse length", prh, 4);
      for (int r = 0; r < 4; r++) begin
         wait_ready("s3 relock ready");
         drop_lock_3();
         chk("s3 saturating count", int'(lock_loss_count), (r + 2 > 3) ? 3 : r + 2);
         if (r < 3) locked_in = 1'b1;
      end

      // Timeout with lock held low
      base = cyc;
      go_to(base + 43);
      chk("s4 timeout_err before", int'(timeout_err), 0);
      chk("s4 pll_rst before", int'(pll_rst), 0);
      tick();
      chk("s4 timeout_err set", int'(timeout_err), 1);
      chk("s4 pll_rst retry", int'(pll_rst), 1);
      go_to(base + 60);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("s4 cleared timeout_err", int'(timeout_err), 0);
      chk("s4 cleared count", int'(lock_loss_count), 0);
      go_to(base + 87);
      chk("s4 pll_rst before 2nd retry", int'(pll_rst), 0);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("s4 2nd retry pll_rst", int'(pll_rst), 1);
      chk("s4 clear beats timeout", int'(timeout_err), 0);

      // force_relock during RELEASE
      locked_in = 1'b1;
      n = 0;
      while (chan_rst != 3'b110 && n < 80) begin
         tick();
         n++;
      end
      chk("s5 reached chan 110", int'(chan_rst), 3'b110);
      force_relock = 1'b1;
      tick();
      force_relock = 1'b0;
      chk("s5 chan after force", int'(chan_rst), 3'b111);
      chk("s5 count after force", int'(lock_loss_count), 0);
      wait_ready("s5 ready after force");
      locked_in = 1'b0;
      repeat (2) tick();
      force_relock = 1'b1;
      tick();
      force_relock = 1'b0;
      chk("s5 chan after force+loss", int'(chan_rst), 3'b111);
      chk("s5 count after force+loss", int'(lock_loss_count), 1);

      // rst in RUN with count=2
      locked_in = 1'b1;
      wait_ready("s6 ready 1");
      drop_lock_3();
      locked_in = 1'b1;
      wait_ready("s6 ready 2");
      chk("s6 count before rst", int'(lock_loss_count), 2);
      rst = 1'b1;
      tick();
      chk("s6 pll_rst", int'(pll_rst), 1);
      chk("s6 chan_rst", int'(chan_rst), 3'b111);
      chk("s6 all_ready", int'(all_ready), 0);
      chk("s6 count", int'(lock_loss_count), 0);
      rst = 1'b0;
      cyc = 0;

      // force_relock in PLL_RESET restarts the reset pulse
      go_to(2);
      force_relock = 1'b1;
      tick();
      force_relock = 1'b0;
      go_to(6);
      chk("s7 pll_rst extended", int'(pll_rst), 1);
      tick();
      chk("s7 pll_rst released", int'(pll_rst), 0);
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
